// File: rtl/parking_pkg.sv
// Shared state encoding, direction constants, default timing and the
// admission rule used by the parking gate scheduler.
package parking_pkg;

  typedef enum logic [1:0] {IDLE, DECIDE, PULSE, GAP} state_t;

  localparam logic DIR_ENTRY = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

  localparam int DEF_NUM_GATES      = 4;
  localparam int DEF_PULSE_CYCLES   = 2;
  localparam int DEF_GAP_CYCLES     = 2;
  localparam int DEF_BARRIER_CYCLES = 8;

  // University cars fall back to the free area when the uni area is full.
  function automatic logic admit(input logic dir, input logic uni,
                                 input logic uni_vac, input logic vac);
    if (dir == DIR_EXIT) return 1'b1;
    if (uni) return uni_vac | vac;
    return vac;
  endfunction

endpackage

// File: rtl/parking_gate_scheduler_if.sv
// Gate-side and occupancy-counter-side signals of the parking gate scheduler.
interface parking_gate_scheduler_if #(
  parameter int NUM_GATES = parking_pkg::DEF_NUM_GATES
);
  logic [NUM_GATES-1:0] gate_req;
  logic [NUM_GATES-1:0] gate_dir;
  logic [NUM_GATES-1:0] gate_uni;
  logic [NUM_GATES-1:0] gate_ack;
  logic [NUM_GATES-1:0] gate_accept;
  logic [NUM_GATES-1:0] barrier_open;
  logic                 uni_is_vacated_space;
  logic                 is_vacated_space;
  logic                 car_entered;
  logic                 is_uni_car_enterd;
  logic                 car_exited;
  logic                 is_uni_car_exited;

  modport master (
    output gate_req, gate_dir, gate_uni, uni_is_vacated_space, is_vacated_space,
    input  gate_ack, gate_accept, barrier_open,
    input  car_entered, is_uni_car_enterd, car_exited, is_uni_car_exited
  );

  modport slave (
    input  gate_req, gate_dir, gate_uni, uni_is_vacated_space, is_vacated_space,
    output gate_ack, gate_accept, barrier_open,
    output car_entered, is_uni_car_enterd, car_exited, is_uni_car_exited
  );
endinterface

// File: rtl/parking_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins,
// wrapping at NUM_GATES.
module parking_rr_arbiter #(
  parameter int NUM_GATES = 4,
  parameter int IDX_W     = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1
) (
  input  logic [NUM_GATES-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_GATES-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_valid
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    pos         = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      pos = IDX_W'((int'(ptr) + i) % NUM_GATES);
      if (!grant_valid && req[pos]) begin
        grant_valid = 1'b1;
        grant_idx   = pos;
        grant[pos]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_gate_scheduler.sv
// Serialises gate entry/exit requests into one-at-a-time occupancy counter
// events, admits or denies entries, and times each gate's barrier.
module parking_gate_scheduler
  import parking_pkg::*;
#(
  parameter int NUM_GATES      = DEF_NUM_GATES,
  parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int BARRIER_CYCLES = DEF_BARRIER_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  parking_gate_scheduler_if.slave  bus,
  output logic                     busy,
  output logic [15:0]              deny_count
);

  localparam int IDX_W = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
  localparam int TW    = $clog2(BARRIER_CYCLES + 1);
  localparam int CW    = 16;

  state_t               state, next_state;
  logic [IDX_W-1:0]     ptr, next_ptr, sel_idx, exit_idx, entry_idx;
  logic [NUM_GATES-1:0] lat_grant, next_grant, exit_grant, entry_grant;
  logic [NUM_GATES-1:0] exit_req, entry_req, barrier_vec;
  logic [NUM_GATES-1:0] ack_q, ack_d, accept_q, accept_d;
  logic                 lat_dir, next_dir, lat_uni, next_uni;
  logic                 exit_valid, entry_valid, accept, load_barrier;
  logic                 entered_q, entered_d, uni_in_q, uni_in_d;
  logic                 exited_q, exited_d, uni_out_q, uni_out_d;
  logic [CW-1:0]        cnt, next_cnt;
  logic [15:0]          deny_d;

  assign exit_req  = bus.gate_req & bus.gate_dir;
  assign entry_req = bus.gate_req & ~bus.gate_dir;

  parking_rr_arbiter #(.NUM_GATES(NUM_GATES), .IDX_W(IDX_W)) u_exit_arb (
    .req(exit_req), .ptr(ptr), .grant(exit_grant),
    .grant_idx(exit_idx), .grant_valid(exit_valid)
  );

  parking_rr_arbiter #(.NUM_GATES(NUM_GATES), .IDX_W(IDX_W)) u_entry_arb (
    .req(entry_req), .ptr(ptr), .grant(entry_grant),
    .grant_idx(entry_idx), .grant_valid(entry_valid)
  );

  assign sel_idx = exit_valid ? exit_idx : entry_idx;
  assign accept  = admit(lat_dir, lat_uni, bus.uni_is_vacated_space, bus.is_vacated_space);

  // Event outputs are computed from next_state so they are registered yet
  // line up with the PULSE state they belong to.
  always_comb begin
    next_state   = state;
    next_ptr     = ptr;
    next_grant   = lat_grant;
    next_dir     = lat_dir;
    next_uni     = lat_uni;
    next_cnt     = cnt;
    ack_d        = '0;
    accept_d     = '0;
    deny_d       = deny_count;
    load_barrier = 1'b0;
    unique case (state)
      IDLE: begin
        if (exit_valid || entry_valid) begin
          next_state = DECIDE;
          next_grant = exit_valid ? exit_grant : entry_grant;
          next_dir   = exit_valid ? DIR_EXIT : DIR_ENTRY;
          next_uni   = |(bus.gate_uni & next_grant);
          next_ptr   = IDX_W'((int'(sel_idx) + 1) % NUM_GATES);
        end
      end
      DECIDE: begin
        ack_d    = lat_grant;
        accept_d = accept ? lat_grant : '0;
        next_cnt = '0;
        if (accept) begin
          next_state = PULSE;
        end else begin
          next_state = GAP;
          if (deny_count != 16'hFFFF) deny_d = deny_count + 16'd1;
        end
      end
      PULSE: begin
        load_barrier = (cnt == '0);
        if (cnt == CW'(PULSE_CYCLES - 1)) begin
          next_state = GAP;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CW'(1);
        end
      end
      default: next_state = IDLE;
    endcase
    entered_d = (next_state == PULSE) && (next_dir == DIR_ENTRY);
    exited_d  = (next_state == PULSE) && (next_dir == DIR_EXIT);
    uni_in_d  = entered_d && next_uni;
    uni_out_d = exited_d && next_uni;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      lat_grant  <= '0;
      lat_dir    <= DIR_ENTRY;
      lat_uni    <= 1'b0;
      cnt        <= '0;
      ack_q      <= '0;
      accept_q   <= '0;
      entered_q  <= 1'b0;
      uni_in_q   <= 1'b0;
      exited_q   <= 1'b0;
      uni_out_q  <= 1'b0;
      deny_count <= '0;
    end else begin
      state      <= next_state;
      ptr        <= next_ptr;
      lat_grant  <= next_grant;
      lat_dir    <= next_dir;
      lat_uni    <= next_uni;
      cnt        <= next_cnt;
      ack_q      <= ack_d;
      accept_q   <= accept_d;
      entered_q  <= entered_d;
      uni_in_q   <= uni_in_d;
      exited_q   <= exited_d;
      uni_out_q  <= uni_out_d;
      deny_count <= deny_d;
    end
  end

  // A reload restarts the timer even if the barrier is still open.
  for (genvar g = 0; g < NUM_GATES; g++) begin : g_barrier
    logic [TW-1:0] timer;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        timer <= '0;
      end else if (load_barrier && lat_grant[g]) begin
        timer <= TW'(BARRIER_CYCLES);
      end else if (timer != '0) begin
        timer <= timer - TW'(1);
      end
    end
    assign barrier_vec[g] = (timer != '0);
  end

  assign busy                  = (state != IDLE);
  assign bus.gate_ack          = ack_q;
  assign bus.gate_accept       = accept_q;
  assign bus.barrier_open      = barrier_vec;
  assign bus.car_entered       = entered_q;
  assign bus.is_uni_car_enterd = uni_in_q;
  assign bus.car_exited        = exited_q;
  assign bus.is_uni_car_exited = uni_out_q;

endmodule
